// File: rtl/gcd_sweep_stream_if.sv
// Byte stream from the GCD sweep engine to the UART transmitter.
// The master presents tx_data/tx_valid; the slave accepts with tx_ready.
interface gcd_sweep_stream_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/gcd_sweep_stream.sv
// Sweeps n over [lo, hi], computes gcd(high half, low half) with a Stein engine
// and streams "n: g\r\n" as ASCII through a registered valid/ready byte port.
module gcd_sweep_stream #(
  parameter int HALF_W = 10,
  parameter int NDIG   = 7,
  parameter int FILTER = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [2*HALF_W-1:0]  lo,
  input  logic [2*HALF_W-1:0]  hi,
  gcd_sweep_stream_if.master   tx,
  output logic                 busy,
  output logic                 result_ready,
  output logic [2*HALF_W:0]    lines
);

  localparam int W2 = 2 * HALF_W;
  localparam int KW = $clog2(HALF_W + 1);
  localparam int CW = $clog2(W2 + 1);
  localparam int DW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam int BW = 4 * NDIG;

  typedef enum logic [3:0] {
    IDLE, LOAD, GCD, CONV_N, EMIT_N, EMIT_COLON, EMIT_SP,
    CONV_G, EMIT_G, EMIT_CR, EMIT_LF, NEXT, DONE
  } state_t;

  state_t              state_q, state_d;
  logic [W2-1:0]       n_q, n_d;
  logic [W2-1:0]       hi_q, hi_d;
  logic [HALF_W-1:0]   opA_q, opA_d;
  logic [HALF_W-1:0]   opB_q, opB_d;
  logic [KW-1:0]       shiftK_q, shiftK_d;
  logic [HALF_W-1:0]   gcd_q, gcd_d;
  logic [W2-1:0]       bin_q, bin_d;
  logic [BW-1:0]       bcd_q, bcd_d;
  logic [CW-1:0]       stepCnt_q, stepCnt_d;
  logic [DW-1:0]       digIdx_q, digIdx_d;
  logic [W2:0]         lineCnt_q, lineCnt_d;
  logic                txValid_q, txValid_d;
  logic [7:0]          txData_q, txData_d;

  logic [HALF_W-1:0]   gcdVal;
  logic [BW-1:0]       bcdAdj, bcdStep;
  logic [DW-1:0]       leadIdx;
  logic                accept;

  assign accept = txValid_q & tx.tx_ready;
  assign gcdVal = (opA_q | opB_q) << shiftK_q;

  // One double-dabble step, plus the most significant non-zero digit of its result
  // so the first printed digit skips leading zeros (all-zero leaves index 0 -> "0").
  always_comb begin
    bcdAdj = bcd_q;
    for (int i = 0; i < NDIG; i++) begin
      if (bcdAdj[i*4 +: 4] >= 4'd5) bcdAdj[i*4 +: 4] = bcdAdj[i*4 +: 4] + 4'd3;
    end
    bcdStep = {bcdAdj[BW-2:0], bin_q[W2-1]};
    leadIdx = '0;
    for (int i = 0; i < NDIG; i++) begin
      if (bcdStep[i*4 +: 4] != 4'd0) leadIdx = DW'(i);
    end
  end

  always_comb begin
    state_d   = state_q;
    n_d       = n_q;
    hi_d      = hi_q;
    opA_d     = opA_q;
    opB_d     = opB_q;
    shiftK_d  = shiftK_q;
    gcd_d     = gcd_q;
    bin_d     = bin_q;
    bcd_d     = bcd_q;
    stepCnt_d = stepCnt_q;
    digIdx_d  = digIdx_q;
    lineCnt_d = lineCnt_q;
    txValid_d = txValid_q;
    txData_d  = txData_q;

    case (state_q)
      IDLE, DONE: ;
      LOAD: begin
        if (n_q > hi_q) begin
          state_d = DONE;
        end else begin
          opA_d    = n_q[W2-1:HALF_W];
          opB_d    = n_q[HALF_W-1:0];
          shiftK_d = '0;
          state_d  = GCD;
        end
      end
      GCD: begin
        if (opA_q == '0 || opB_q == '0) begin
          gcd_d = gcdVal;
          if (FILTER != 0 && gcdVal == HALF_W'(1)) begin
            state_d = NEXT;
          end else begin
            bin_d     = n_q;
            bcd_d     = '0;
            stepCnt_d = '0;
            state_d   = CONV_N;
          end
        end else if (!opA_q[0] && !opB_q[0]) begin
          opA_d    = opA_q >> 1;
          opB_d    = opB_q >> 1;
          shiftK_d = shiftK_q + KW'(1);
        end else if (!opA_q[0]) begin
          opA_d = opA_q >> 1;
        end else if (!opB_q[0]) begin
          opB_d = opB_q >> 1;
        end else if (opA_q >= opB_q) begin
          opA_d = opA_q - opB_q;
        end else begin
          opB_d = opB_q - opA_q;
        end
      end
      // The first digit is presented on the last conversion step, so every
      // EMIT_* state is entered with tx_valid already high.
      CONV_N, CONV_G: begin
        bcd_d     = bcdStep;
        bin_d     = bin_q << 1;
        stepCnt_d = stepCnt_q + CW'(1);
        if (stepCnt_q == CW'(W2 - 1)) begin
          digIdx_d  = leadIdx;
          txValid_d = 1'b1;
          txData_d  = {4'h3, bcdStep[leadIdx*4 +: 4]};
          state_d   = (state_q == CONV_N) ? EMIT_N : EMIT_G;
        end
      end
      EMIT_N, EMIT_G: begin
        if (accept) begin
          if (digIdx_q == '0) begin
            txData_d = (state_q == EMIT_N) ? 8'h3A : 8'h0D;
            state_d  = (state_q == EMIT_N) ? EMIT_COLON : EMIT_CR;
          end else begin
            digIdx_d = digIdx_q - DW'(1);
            txData_d = {4'h3, bcd_q[digIdx_d*4 +: 4]};
          end
        end
      end
      EMIT_COLON: begin
        if (accept) begin
          txData_d = 8'h20;
          state_d  = EMIT_SP;
        end
      end
      EMIT_SP: begin
        if (accept) begin
          txValid_d = 1'b0;
          bin_d     = {{HALF_W{1'b0}}, gcd_q};
          bcd_d     = '0;
          stepCnt_d = '0;
          state_d   = CONV_G;
        end
      end
      EMIT_CR: begin
        if (accept) begin
          txData_d = 8'h0A;
          state_d  = EMIT_LF;
        end
      end
      EMIT_LF: begin
        if (accept) begin
          txValid_d = 1'b0;
          lineCnt_d = lineCnt_q + (W2+1)'(1);
          state_d   = NEXT;
        end
      end
      // Compare before incrementing so hi = all-ones ends without wrapping.
      NEXT: begin
        if (n_q == hi_q) begin
          state_d = DONE;
        end else begin
          n_d     = n_q + W2'(1);
          state_d = LOAD;
        end
      end
      default: state_d = IDLE;
    endcase

    if (start) begin
      n_d       = lo;
      hi_d      = hi;
      lineCnt_d = '0;
      txValid_d = 1'b0;
      state_d   = LOAD;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      n_q       <= '0;
      hi_q      <= '0;
      opA_q     <= '0;
      opB_q     <= '0;
      shiftK_q  <= '0;
      gcd_q     <= '0;
      bin_q     <= '0;
      bcd_q     <= '0;
      stepCnt_q <= '0;
      digIdx_q  <= '0;
      lineCnt_q <= '0;
      txValid_q <= 1'b0;
      txData_q  <= '0;
    end else begin
      state_q   <= state_d;
      n_q       <= n_d;
      hi_q      <= hi_d;
      opA_q     <= opA_d;
      opB_q     <= opB_d;
      shiftK_q  <= shiftK_d;
      gcd_q     <= gcd_d;
      bin_q     <= bin_d;
      bcd_q     <= bcd_d;
      stepCnt_q <= stepCnt_d;
      digIdx_q  <= digIdx_d;
      lineCnt_q <= lineCnt_d;
      txValid_q <= txValid_d;
      txData_q  <= txData_d;
    end
  end

  assign tx.tx_valid   = txValid_q;
  assign tx.tx_data    = txData_q;
  assign busy          = (state_q != IDLE) && (state_q != DONE);
  assign result_ready  = ~busy & ~start;
  assign lines         = lineCnt_q;

endmodule

// File: tb/tb_gcd_sweep_stream.sv
// Three gcd_sweep_stream instances (4-bit halves, 4-bit halves filtered, 10-bit halves)
// checked against a Euclid/$sformatf reference of the expected ASCII stream.
module tb_gcd_sweep_stream;

  logic clk = 1'b0;
  logic rst_n;
  logic start0, start1, start2;
  logic [7:0]  lo0, hi0, lo1, hi1;
  logic [19:0] lo2, hi2;
  logic busy0, busy1, busy2;
  logic rr0, rr1, rr2;
  logic [8:0]  lines0, lines1;
  logic [20:0] lines2;
  int checks;
  int failures;

  logic [7:0] cap0[$];
  logic [7:0] cap1[$];
  logic [7:0] cap2[$];

  gcd_sweep_stream_if txIf0();
  gcd_sweep_stream_if txIf1();
  gcd_sweep_stream_if txIf2();

  gcd_sweep_stream #(.HALF_W(4), .NDIG(3), .FILTER(0)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .lo(lo0), .hi(hi0), .tx(txIf0.master),
    .busy(busy0), .result_ready(rr0), .lines(lines0));
  gcd_sweep_stream #(.HALF_W(4), .NDIG(3), .FILTER(1)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .lo(lo1), .hi(hi1), .tx(txIf1.master),
    .busy(busy1), .result_ready(rr1), .lines(lines1));
  gcd_sweep_stream #(.HALF_W(10), .NDIG(7), .FILTER(0)) u2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .lo(lo2), .hi(hi2), .tx(txIf2.master),
    .busy(busy2), .result_ready(rr2), .lines(lines2));

  always #5 clk = ~clk;

  // Every accepted byte is recorded; tests compare slices from a recorded base index.
  always @(posedge clk) begin
    if (txIf0.tx_valid && txIf0.tx_ready) cap0.push_back(txIf0.tx_data);
    if (txIf1.tx_valid && txIf1.tx_ready) cap1.push_back(txIf1.tx_data);
    if (txIf2.tx_valid && txIf2.tx_ready) cap2.push_back(txIf2.tx_data);
  end

  initial begin
    #600000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic int gcdRef(input int a, input int b);
    int x, y, t;
    x = a;
    y = b;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  function automatic string modelHex(input int hw, input int filt, input int loV,
                                     input int hiV, output int nLines);
    string s, ln;
    int g;
    s = "";
    nLines = 0;
    for (int n = loV; n <= hiV; n++) begin
      g = gcdRef(n >> hw, n % (1 << hw));
      if (filt != 0 && g == 1) continue;
      ln = $sformatf("%0d: %0d%c%c", n, g, 8'h0D, 8'h0A);
      for (int i = 0; i < ln.len(); i++) s = {s, $sformatf("%02x", ln[i])};
      nLines++;
    end
    return s;
  endfunction

  function automatic int capSize(input int inst);
    case (inst)
      0: return cap0.size();
      1: return cap1.size();
      default: return cap2.size();
    endcase
  endfunction

  function automatic string capHex(input int inst, input int from);
    string s;
    logic [7:0] b;
    s = "";
    for (int i = from; i < capSize(inst); i++) begin
      case (inst)
        0: b = cap0[i];
        1: b = cap1[i];
        default: b = cap2[i];
      endcase
      s = {s, $sformatf("%02x", b)};
    end
    return s;
  endfunction

  function automatic bit busyOf(input int inst);
    case (inst)
      0: return busy0;
      1: return busy1;
      default: return busy2;
    endcase
  endfunction

  function automatic int linesOf(input int inst);
    case (inst)
      0: return int'(lines0);
      1: return int'(lines1);
      default: return int'(lines2);
    endcase
  endfunction

  task automatic setReady(input int inst, input logic v);
    case (inst)
      0: txIf0.tx_ready = v;
      1: txIf1.tx_ready = v;
      default: txIf2.tx_ready = v;
    endcase
  endtask

  task automatic applyStimulus(input int inst, input int loV, input int hiV);
    @(negedge clk);
    case (inst)
      0: begin lo0 = loV[7:0];  hi0 = hiV[7:0];  start0 = 1'b1; end
      1: begin lo1 = loV[7:0];  hi1 = hiV[7:0];  start1 = 1'b1; end
      default: begin lo2 = loV[19:0]; hi2 = hiV[19:0]; start2 = 1'b1; end
    endcase
    @(negedge clk);
    start0 = 1'b0;
    start1 = 1'b0;
    start2 = 1'b0;
  endtask

  task automatic waitIdle(input int inst, input bit rnd, output int cyc);
    cyc = 0;
    while (busyOf(inst) && cyc < 2000) begin
      if (rnd) setReady(inst, 1'($urandom_range(0, 1)));
      @(negedge clk);
      cyc++;
    end
    setReady(inst, 1'b1);
    if (busyOf(inst)) begin
      checks++;
      failures++;
      $display("[TB] FAIL timeout inst%0d: busy still 1 after %0d cycles, required 0", inst, cyc);
    end
  endtask

  task automatic runSweep(input int inst, input int loV, input int hiV, input bit rnd,
                          output int base, output int cyc);
    base = capSize(inst);
    applyStimulus(inst, loV, hiV);
    waitIdle(inst, rnd, cyc);
  endtask

  task automatic test_reset();
    #3;
    checks += 4;
    if (txIf0.tx_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_valid: got %b, required 0", txIf0.tx_valid); end
    if (txIf0.tx_data !== 8'h00) begin failures++; $display("[TB] FAIL reset_data: got %h, required 00", txIf0.tx_data); end
    if (busy2 !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy: got %b, required 0", busy2); end
    if (lines2 !== '0) begin failures++; $display("[TB] FAIL reset_lines: got %0d, required 0", lines2); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks += 2;
    if (rr0 !== 1'b1) begin failures++; $display("[TB] FAIL reset_rr0: got %b, required 1", rr0); end
    if (rr2 !== 1'b1) begin failures++; $display("[TB] FAIL reset_rr2: got %b, required 1", rr2); end
    lo0 = 8'h05;
    hi0 = 8'h02;
    start0 = 1'b1;
    #1;
    checks++;
    if (rr0 !== 1'b0) begin failures++; $display("[TB] FAIL rr_with_start: got %b, required 0", rr0); end
    start0 = 1'b0;
  endtask

  task automatic test_basic_sweep();
    int base, cyc, nl;
    string exp, act;
    exp = modelHex(4, 0, 0, 3, nl);
    runSweep(0, 8'h00, 8'h03, 1'b0, base, cyc);
    act = capHex(0, base);
    checks += 3;
    if (act != exp) begin failures++; $display("[TB] FAIL basic_stream: got %s, required %s", act, exp); end
    if (linesOf(0) !== nl) begin failures++; $display("[TB] FAIL basic_lines: got %0d, required %0d", linesOf(0), nl); end
    if (rr0 !== 1'b1) begin failures++; $display("[TB] FAIL basic_rr: got %b, required 1", rr0); end
  endtask

  task automatic test_single_values();
    int base, cyc, nl, sz;
    string exp, act;
    exp = modelHex(4, 0, 8'h6C, 8'h6C, nl);
    runSweep(0, 8'h6C, 8'h6C, 1'b0, base, cyc);
    act = capHex(0, base);
    checks++;
    if (act != exp) begin failures++; $display("[TB] FAIL single_108: got %s, required %s", act, exp); end
    exp = modelHex(4, 0, 8'hFF, 8'hFF, nl);
    runSweep(0, 8'hFF, 8'hFF, 1'b0, base, cyc);
    act = capHex(0, base);
    sz = capSize(0);
    repeat (30) @(negedge clk);
    checks += 4;
    if (act != exp) begin failures++; $display("[TB] FAIL single_255: got %s, required %s", act, exp); end
    if (linesOf(0) !== 1) begin failures++; $display("[TB] FAIL single_255_lines: got %0d, required 1", linesOf(0)); end
    if (capSize(0) !== sz) begin failures++; $display("[TB] FAIL no_wrap_bytes: got %0d, required %0d", capSize(0), sz); end
    if (busy0 !== 1'b0) begin failures++; $display("[TB] FAIL no_wrap_busy: got %b, required 0", busy0); end
  endtask

  task automatic test_filter();
    int base, cyc, nl;
    string exp, act;
    runSweep(1, 8'h10, 8'h13, 1'b0, base, cyc);
    checks += 2;
    if (capSize(1) !== base) begin failures++; $display("[TB] FAIL filter_none_bytes: got %0d, required 0", capSize(1) - base); end
    if (linesOf(1) !== 0) begin failures++; $display("[TB] FAIL filter_none_lines: got %0d, required 0", linesOf(1)); end
    exp = modelHex(4, 1, 8'h20, 8'h24, nl);
    runSweep(1, 8'h20, 8'h24, 1'b0, base, cyc);
    act = capHex(1, base);
    checks += 2;
    if (act != exp) begin failures++; $display("[TB] FAIL filter_stream: got %s, required %s", act, exp); end
    if (linesOf(1) !== nl) begin failures++; $display("[TB] FAIL filter_lines: got %0d, required %0d", linesOf(1), nl); end
  endtask

  task automatic test_backpressure();
    int base, cyc, nl, holdErr;
    string exp, act, ln;
    logic [7:0] d0;
    logic v0;
    exp = modelHex(10, 0, 20'hFFC00, 20'hFFC00, nl);
    ln = $sformatf("%0d: %0d", 20'hFFC00, 1023);
    base = capSize(2);
    applyStimulus(2, 20'hFFC00, 20'hFFC00);
    cyc = 0;
    while (capSize(2) < base + 3 && cyc < 500) begin
      @(negedge clk);
      cyc++;
    end
    setReady(2, 1'b0);
    d0 = txIf2.tx_data;
    v0 = txIf2.tx_valid;
    holdErr = 0;
    repeat (50) begin
      @(negedge clk);
      if (txIf2.tx_valid !== 1'b1 || txIf2.tx_data !== d0) holdErr++;
    end
    checks += 3;
    if (v0 !== 1'b1) begin failures++; $display("[TB] FAIL bp_valid: got %b, required 1", v0); end
    if (d0 !== ln[3]) begin failures++; $display("[TB] FAIL bp_data: got %h, required %h", d0, ln[3]); end
    if (holdErr != 0) begin failures++; $display("[TB] FAIL bp_hold: got %0d unstable cycles, required 0", holdErr); end
    setReady(2, 1'b1);
    waitIdle(2, 1'b0, cyc);
    act = capHex(2, base);
    checks += 2;
    if (act != exp) begin failures++; $display("[TB] FAIL bp_stream: got %s, required %s", act, exp); end
    if (linesOf(2) !== 1) begin failures++; $display("[TB] FAIL bp_lines: got %0d, required 1", linesOf(2)); end
    runSweep(2, 20'hFFC00, 20'hFFC00, 1'b1, base, cyc);
    act = capHex(2, base);
    checks++;
    if (act != exp) begin failures++; $display("[TB] FAIL bp_random_stream: got %s, required %s", act, exp); end
  endtask

  task automatic test_empty_range();
    int base, cyc;
    runSweep(0, 8'h05, 8'h02, 1'b0, base, cyc);
    checks += 3;
    if (capSize(0) !== base) begin failures++; $display("[TB] FAIL empty_bytes: got %0d, required 0", capSize(0) - base); end
    if (cyc > 2) begin failures++; $display("[TB] FAIL empty_busy: got %0d cycles, required <=2", cyc); end
    if (linesOf(0) !== 0) begin failures++; $display("[TB] FAIL empty_lines: got %0d, required 0", linesOf(0)); end
  endtask

  task automatic test_reset_midline();
    int base, cyc, sz;
    base = capSize(2);
    applyStimulus(2, 20'hFFC00, 20'hFFC01);
    cyc = 0;
    while (capSize(2) < base + 18 && cyc < 1000) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (linesOf(2) !== 1) begin failures++; $display("[TB] FAIL rstmid_pre_lines: got %0d, required 1", linesOf(2)); end
    #2;
    rst_n = 1'b0;
    #1;
    checks += 3;
    if (txIf2.tx_valid !== 1'b0) begin failures++; $display("[TB] FAIL rstmid_valid: got %b, required 0", txIf2.tx_valid); end
    if (busy2 !== 1'b0) begin failures++; $display("[TB] FAIL rstmid_busy: got %b, required 0", busy2); end
    if (lines2 !== '0) begin failures++; $display("[TB] FAIL rstmid_lines: got %0d, required 0", lines2); end
    sz = capSize(2);
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    checks += 2;
    if (capSize(2) !== sz) begin failures++; $display("[TB] FAIL rstmid_bytes: got %0d extra, required 0", capSize(2) - sz); end
    if (busy2 !== 1'b0) begin failures++; $display("[TB] FAIL rstmid_idle: got %b, required 0", busy2); end
  endtask

  task automatic test_start_midline();
    int base, cyc, mid, nl;
    string exp, act;
    exp = modelHex(4, 0, 8'h10, 8'h11, nl);
    base = capSize(0);
    applyStimulus(0, 8'h6C, 8'h6D);
    cyc = 0;
    while (capSize(0) < base + 3 && cyc < 500) begin
      @(negedge clk);
      cyc++;
    end
    setReady(0, 1'b0);
    applyStimulus(0, 8'h10, 8'h11);
    checks++;
    if (txIf0.tx_valid !== 1'b0) begin failures++; $display("[TB] FAIL startmid_valid: got %b, required 0", txIf0.tx_valid); end
    mid = capSize(0);
    setReady(0, 1'b1);
    waitIdle(0, 1'b0, cyc);
    act = capHex(0, mid);
    checks += 2;
    if (act != exp) begin failures++; $display("[TB] FAIL startmid_stream: got %s, required %s", act, exp); end
    if (linesOf(0) !== nl) begin failures++; $display("[TB] FAIL startmid_lines: got %0d, required %0d", linesOf(0), nl); end
  endtask

  task automatic test_random();
    int base, cyc, nl, inst, loV, hiV, hw, maxV;
    string exp, act;
    for (int it = 0; it < 9; it++) begin
      inst = it % 3;
      hw   = (inst == 2) ? 10 : 4;
      maxV = (1 << (2 * hw)) - 1;
      loV  = int'($urandom_range(0, maxV));
      hiV  = loV + int'($urandom_range(0, (inst == 2) ? 2 : 4));
      if (hiV > maxV) hiV = maxV;
      exp = modelHex(hw, (inst == 1) ? 1 : 0, loV, hiV, nl);
      runSweep(inst, loV, hiV, 1'b1, base, cyc);
      act = capHex(inst, base);
      checks += 2;
      if (act != exp) begin failures++; $display("[TB] FAIL random_stream inst%0d %0d..%0d: got %s, required %s", inst, loV, hiV, act, exp); end
      if (linesOf(inst) !== nl) begin failures++; $display("[TB] FAIL random_lines inst%0d: got %0d, required %0d", inst, linesOf(inst), nl); end
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
    lo0 = '0; hi0 = '0; lo1 = '0; hi1 = '0; lo2 = '0; hi2 = '0;
    txIf0.tx_ready = 1'b1;
    txIf1.tx_ready = 1'b1;
    txIf2.tx_ready = 1'b1;
    test_reset();
    test_basic_sweep();
    test_single_values();
    test_filter();
    test_backpressure();
    test_empty_range();
    test_reset_midline();
    test_start_midline();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
